// File: rtl/ts_pkg.sv
// Shared constants and helpers for the timestamp unit.
package ts_pkg;

   localparam int unsigned TS_W   = 64;
   localparam int unsigned FRAC_W = 32;

   // Nominal per-tick increment: round(2^frac_w / tick_hz).
   function automatic logic [63:0] calc_inc(input int unsigned frac_w,
                                            input int unsigned tick_hz);
      logic [63:0] num;
      num = 64'd1 << frac_w;
      return (num + 64'(tick_hz / 2)) / 64'(tick_hz);
   endfunction

endpackage

// File: rtl/time_stamp_unit_if.sv
// Host-side bus of the timestamp unit: load, trim, events and capture handshake.
interface time_stamp_unit_if #(
   parameter int unsigned TS_W = ts_pkg::TS_W,
   parameter int unsigned N_CH = 4
);

   logic                   i_time_stamp_sig;
   logic [TS_W-1:0]        i_time_stamp_set;
   logic [15:0]            i_trim;
   logic [N_CH-1:0]        i_evt;
   logic [N_CH-1:0]        i_cap_ack;
   logic [TS_W-1:0]        o_time_stamp_get;
   logic                   o_pps;
   logic [N_CH-1:0]        o_cap_valid;
   logic [N_CH*TS_W-1:0]   o_cap_ts;
   logic [N_CH-1:0]        o_cap_ovf;

   modport master (
      output i_time_stamp_sig, i_time_stamp_set, i_trim, i_evt, i_cap_ack,
      input  o_time_stamp_get, o_pps, o_cap_valid, o_cap_ts, o_cap_ovf
   );

   modport slave (
      input  i_time_stamp_sig, i_time_stamp_set, i_trim, i_evt, i_cap_ack,
      output o_time_stamp_get, o_pps, o_cap_valid, o_cap_ts, o_cap_ovf
   );

endinterface

// File: rtl/ts_evt_capture.sv
// One event channel: synchroniser, rising-edge detect and a single-entry capture slot.
module ts_evt_capture #(
   parameter int unsigned TS_W        = ts_pkg::TS_W,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic            i_clk_50m,
   input  logic            i_rst_n,
   input  logic            evt,
   input  logic            cap_ack,
   input  logic [TS_W-1:0] time_now,
   output logic            cap_valid,
   output logic [TS_W-1:0] cap_ts,
   output logic            cap_ovf
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;
   // Marks which stages hold real samples since reset; an input already high at
   // reset release must not look like a rising edge.
   logic [SYNC_STAGES:0]   prime_q;
   logic                   rise;

   logic                   valid_q, valid_d;
   logic                   ovf_q, ovf_d;
   logic [TS_W-1:0]        ts_q, ts_d;

   // Synchroniser, delay flop and priming shift register.
   always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q  <= '0;
         dly_q   <= 1'b0;
         prime_q <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], evt};
         dly_q   <= sync_q[SYNC_STAGES-1];
         prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~dly_q & prime_q[SYNC_STAGES];

   // Capture slot: first capture wins until acked; ack in the same cycle frees the slot.
   always_comb begin
      valid_d = valid_q;
      ovf_d   = ovf_q;
      ts_d    = ts_q;
      if (rise) begin
         if (!valid_q || cap_ack) begin
            ts_d    = time_now;
            valid_d = 1'b1;
            ovf_d   = 1'b0;
         end else begin
            ovf_d   = 1'b1;
         end
      end else if (cap_ack && valid_q) begin
         valid_d = 1'b0;
         ovf_d   = 1'b0;
      end
   end

   // Capture state registers.
   always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         ts_q    <= '0;
      end else begin
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         ts_q    <= ts_d;
      end
   end

   assign cap_valid = valid_q;
   assign cap_ovf   = ovf_q;
   assign cap_ts    = ts_q;

endmodule

// File: rtl/time_stamp_unit.sv
// Fixed-point time accumulator with microsecond tick, host load, PPS and event capture.
module time_stamp_unit #(
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned TICK_HZ     = 1_000_000,
   parameter int unsigned TS_W        = ts_pkg::TS_W,
   parameter int unsigned FRAC_W      = ts_pkg::FRAC_W,
   parameter int unsigned N_CH        = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              i_clk_50m,
   input  logic              i_rst_n,
   time_stamp_unit_if.slave  bus
);

   import ts_pkg::*;

   localparam int unsigned     DIV      = CLK_HZ / TICK_HZ;
   localparam int unsigned     DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [TS_W-1:0] INC      = TS_W'(calc_inc(FRAC_W, TICK_HZ));

   logic [DIV_W-1:0] div_q, div_d;
   logic             tick;
   logic [TS_W-1:0]  ts_q, ts_d;
   logic [TS_W-1:0]  delta;
   logic [TS_W-1:0]  sum;
   logic             pps_q, pps_d;

   assign tick  = (div_q == DIV_LAST);
   // Trim is sampled live on the tick cycle, so a change lands on the next tick.
   assign delta = INC + {{(TS_W-16){bus.i_trim[15]}}, bus.i_trim};
   assign sum   = ts_q + delta;

   // Divider, accumulator and PPS next state; a load drops a coincident tick.
   always_comb begin
      div_d = tick ? '0 : div_q + 1'b1;
      ts_d  = ts_q;
      pps_d = 1'b0;
      if (bus.i_time_stamp_sig) begin
         div_d = '0;
         ts_d  = bus.i_time_stamp_set;
      end else if (tick) begin
         ts_d  = sum;
         // Only an upward carry into the seconds field counts.
         pps_d = ~delta[TS_W-1] & (sum[TS_W-1:FRAC_W] != ts_q[TS_W-1:FRAC_W]);
      end
   end

   // Divider, time and PPS registers.
   always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         div_q <= '0;
         ts_q  <= '0;
         pps_q <= 1'b0;
      end else begin
         div_q <= div_d;
         ts_q  <= ts_d;
         pps_q <= pps_d;
      end
   end

   logic [N_CH-1:0]      cap_valid;
   logic [N_CH-1:0]      cap_ovf;
   logic [N_CH*TS_W-1:0] cap_ts;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      ts_evt_capture #(
         .TS_W        (TS_W),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_cap (
         .i_clk_50m (i_clk_50m),
         .i_rst_n   (i_rst_n),
         .evt       (bus.i_evt[k]),
         .cap_ack   (bus.i_cap_ack[k]),
         .time_now  (ts_q),
         .cap_valid (cap_valid[k]),
         .cap_ts    (cap_ts[k*TS_W +: TS_W]),
         .cap_ovf   (cap_ovf[k])
      );
   end

   assign bus.o_time_stamp_get = ts_q;
   assign bus.o_pps            = pps_q;
   assign bus.o_cap_valid      = cap_valid;
   assign bus.o_cap_ts         = cap_ts;
   assign bus.o_cap_ovf        = cap_ovf;

endmodule

// File: tb/tb_time_stamp_unit.sv
// Self-checking bench for time_stamp_unit at default parameters.
module tb_time_stamp_unit;

   localparam int unsigned N_CH = 4;
   localparam int unsigned TS_W = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #10 clk = ~clk;

   time_stamp_unit_if #(.TS_W(TS_W), .N_CH(N_CH)) bus ();

   time_stamp_unit #(
      .CLK_HZ      (50_000_000),
      .TICK_HZ     (1_000_000),
      .TS_W        (TS_W),
      .FRAC_W      (32),
      .N_CH        (N_CH),
      .SYNC_STAGES (2)
   ) dut (
      .i_clk_50m (clk),
      .i_rst_n   (rst_n),
      .bus       (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [63:0] exp_q[$];

   typedef struct {
      logic [63:0] load_val;
      logic [15:0] trim;
      logic [63:0] exp_ts;
      int          exp_pps;
   } vec_t;

   vec_t vecs[7];

   localparam logic [63:0] LA = 64'h0000_0012_3456_0000;
   localparam logic [63:0] LB = 64'h0000_0034_0000_ABCD;
   localparam logic [63:0] LC = 64'h0000_0056_7800_0001;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input logic [63:0] v);
      bus.i_time_stamp_sig = 1'b1;
      bus.i_time_stamp_set = v;
      step();
      bus.i_time_stamp_sig = 1'b0;
   endtask

   function automatic logic [63:0] cap_of(input int k);
      return bus.o_cap_ts[k*TS_W +: TS_W];
   endfunction

   initial begin
      int   cnt;
      logic pps_at;

      bus.i_time_stamp_sig = 1'b0;
      bus.i_time_stamp_set = '0;
      bus.i_trim           = '0;
      bus.i_evt            = '0;
      bus.i_cap_ack        = '0;

      vecs[0] = '{64'h0000_0001_0000_0000, 16'h0000, 64'h0000_0001_0000_10C7, 0};
      vecs[1] = '{64'h0000_0000_FFFF_F000, 16'h0000, 64'h0000_0001_0000_00C7, 1};
      vecs[2] = '{64'h0000_0000_0000_0000, 16'hFFFB, 64'd4290, 0};
      vecs[3] = '{64'h0000_0000_0000_0000, 16'h0005, 64'd4300, 0};
      vecs[4] = '{64'h0000_0001_0000_0000, 16'hEF34, 64'h0000_0000_FFFF_FFFB, 0};
      vecs[5] = '{64'h0000_0007_FFFF_FFFF, 16'h0000, 64'h0000_0008_0000_10C6, 1};
      vecs[6] = '{64'h0000_0000_0000_0000, 16'h7FFF, 64'd37062, 0};

      // Reset state.
      step(3);
      check("rst_ts", bus.o_time_stamp_get, 64'd0);
      check("rst_pps", 64'(bus.o_pps), 64'd0);
      check("rst_valid", 64'(bus.o_cap_valid), 64'd0);
      check("rst_ovf", 64'(bus.o_cap_ovf), 64'd0);
      for (int k = 0; k < N_CH; k++) check($sformatf("rst_cap_ts%0d", k), cap_of(k), 64'd0);

      // Free-running ticks from reset release.
      rst_n = 1'b1;
      cnt = 0;
      for (int e = 1; e <= 100; e++) begin
         step();
         cnt += int'(bus.o_pps);
         if (e == 49) check("ts_edge49", bus.o_time_stamp_get, 64'd0);
         if (e == 50) check("ts_edge50", bus.o_time_stamp_get, 64'd4295);
         if (e == 99) check("ts_edge99", bus.o_time_stamp_get, 64'd4295);
         if (e == 100) check("ts_edge100", bus.o_time_stamp_get, 64'd8590);
      end
      check("pps_free_run", 64'(cnt), 64'd0);

      // Load coincident with a tick: loaded value wins, no increment.
      step(49);
      check("ts_pre_coincident", bus.o_time_stamp_get, 64'd8590);
      do_load(64'h0000_0005_0000_0000);
      check("load_over_tick", bus.o_time_stamp_get, 64'h0000_0005_0000_0000);
      check("load_no_pps", 64'(bus.o_pps), 64'd0);
      step(49);
      check("after_load_49", bus.o_time_stamp_get, 64'h0000_0005_0000_0000);
      step();
      check("after_load_50", bus.o_time_stamp_get, 64'h0000_0005_0000_10C7);

      // Table of load/trim/step vectors.
      for (int i = 0; i < 7; i++) begin
         bus.i_trim = vecs[i].trim;
         step(17 + i);
         do_load(vecs[i].load_val);
         exp_q.push_back(vecs[i].exp_ts);
         check($sformatf("v%0d_load", i), bus.o_time_stamp_get, vecs[i].load_val);
         cnt = int'(bus.o_pps);
         pps_at = 1'b0;
         for (int e = 1; e <= 50; e++) begin
            step();
            cnt += int'(bus.o_pps);
            if (e == 49) check($sformatf("v%0d_hold", i), bus.o_time_stamp_get, vecs[i].load_val);
            if (e == 50) pps_at = bus.o_pps;
         end
         check($sformatf("v%0d_step", i), bus.o_time_stamp_get, exp_q.pop_front());
         check($sformatf("v%0d_pps_align", i), 64'(pps_at), 64'(vecs[i].exp_pps != 0));
         step();
         cnt += int'(bus.o_pps);
         check($sformatf("v%0d_pps_count", i), 64'(cnt), 64'(vecs[i].exp_pps));
      end

      // Trim changed mid-period applies at the next tick only.
      bus.i_trim = 16'h0000;
      do_load(64'd0);
      step(25);
      bus.i_trim = 16'h0005;
      step(24);
      check("trim_mid_hold", bus.o_time_stamp_get, 64'd0);
      step();
      check("trim_mid_tick1", bus.o_time_stamp_get, 64'd4300);
      bus.i_trim = 16'hFFFB;
      step(50);
      check("trim_mid_tick2", bus.o_time_stamp_get, 64'd8590);
      bus.i_trim = 16'h0000;

      // Single-channel capture, overflow, ack and ack+rise.
      do_load(LA);
      bus.i_evt = 4'b0001;
      exp_q.push_back(LA);
      step(2);
      check("cap_early", 64'(bus.o_cap_valid), 64'd0);
      step();
      check("cap_valid", 64'(bus.o_cap_valid), 64'h1);
      check("cap_ts", cap_of(0), exp_q.pop_front());
      check("cap_ovf0", 64'(bus.o_cap_ovf), 64'd0);
      bus.i_evt = 4'b0000;
      step(3);
      bus.i_evt = 4'b0001;
      step(3);
      check("ovf_set", 64'(bus.o_cap_ovf), 64'h1);
      check("ovf_ts_kept", cap_of(0), LA);
      check("ovf_valid", 64'(bus.o_cap_valid), 64'h1);
      bus.i_evt = 4'b0000;
      step(3);
      do_load(LB);
      exp_q.push_back(LB);
      bus.i_evt = 4'b0001;
      step(2);
      bus.i_cap_ack = 4'b0001;
      step();
      bus.i_cap_ack = 4'b0000;
      check("ackrise_valid", 64'(bus.o_cap_valid), 64'h1);
      check("ackrise_ovf", 64'(bus.o_cap_ovf), 64'd0);
      check("ackrise_ts", cap_of(0), exp_q.pop_front());
      bus.i_evt = 4'b0000;
      step(3);
      bus.i_cap_ack = 4'b0001;
      step();
      bus.i_cap_ack = 4'b0000;
      check("ack_valid", 64'(bus.o_cap_valid), 64'd0);
      check("ack_ovf", 64'(bus.o_cap_ovf), 64'd0);
      check("ack_ts_hold", cap_of(0), LB);
      bus.i_cap_ack = 4'b0001;
      step();
      bus.i_cap_ack = 4'b0000;
      check("ack_idle", 64'(bus.o_cap_valid), 64'd0);

      // All channels together, independent acks, then overflow on the unacked ones.
      do_load(LC);
      bus.i_evt = 4'hF;
      step(3);
      check("all_valid", 64'(bus.o_cap_valid), 64'hF);
      for (int k = 0; k < N_CH; k++) check($sformatf("all_ts%0d", k), cap_of(k), LC);
      bus.i_cap_ack = 4'b0101;
      step();
      bus.i_cap_ack = 4'b0000;
      check("part_ack_valid", 64'(bus.o_cap_valid), 64'hA);
      bus.i_evt = 4'h0;
      step(3);
      bus.i_evt = 4'hF;
      step(3);
      check("all2_valid", 64'(bus.o_cap_valid), 64'hF);
      check("all2_ovf", 64'(bus.o_cap_ovf), 64'hA);
      check("all2_ts1_kept", cap_of(1), LC);

      // Asynchronous reset clears everything without a clock edge.
      rst_n = 1'b0;
      #2;
      check("arst_ts", bus.o_time_stamp_get, 64'd0);
      check("arst_valid", 64'(bus.o_cap_valid), 64'd0);
      check("arst_ovf", 64'(bus.o_cap_ovf), 64'd0);
      check("arst_pps", 64'(bus.o_pps), 64'd0);
      for (int k = 0; k < N_CH; k++) check($sformatf("arst_ts%0d", k), cap_of(k), 64'd0);

      // Event held high across reset release is not captured until it re-rises.
      step(2);
      rst_n = 1'b1;
      step(10);
      check("held_no_cap", 64'(bus.o_cap_valid), 64'd0);
      bus.i_evt = 4'h0;
      step(3);
      bus.i_evt = 4'hF;
      step(3);
      check("rearm_valid", 64'(bus.o_cap_valid), 64'hF);
      check("rearm_ts3", cap_of(3), 64'd0);
      bus.i_evt = 4'h0;
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/time_stamp_unit.md
# time_stamp_unit

Parametrised timestamp generator with per-channel event capture, the successor to the single-counter timestamp block in the laser timing path. Maintains a 64-bit fixed-point time value: integer seconds in the upper bits, binary fraction of a second in the lower FRAC_W bits. The value advances once per microsecond tick by a trimmable increment and can be loaded from the host, for example for PPS or host time-sync. The block latches the current time on rising edges of up to N_CH asynchronous event inputs and hands each capture out with a valid/ack handshake.

## Interface
- CLK_HZ, 50_000_000: input clock frequency.
- TICK_HZ, 1_000_000: tick rate. DIV = CLK_HZ/TICK_HZ must be an integer ≥ 2.
- TS_W, 64: timestamp width.
- FRAC_W, 32: fraction bits. Nominal increment INC = round(2^FRAC_W / TICK_HZ), which is 4295 at the defaults.
- N_CH, 4: number of event capture channels, 1..8.
- SYNC_STAGES, 2: synchroniser depth on each event input, ≥ 2.
- i_clk_50m, in, 1: clock.
- i_rst_n, in, 1: reset, asynchronous, active-low.
- i_time_stamp_sig, in, 1: load strobe, one cycle.
- i_time_stamp_set, in, TS_W: value to load.
- i_trim, in, 16: signed per-tick increment correction, static or quasi-static.
- i_evt, in, N_CH: asynchronous event inputs.
- i_cap_ack, in, N_CH: per-channel capture acknowledge.
- o_time_stamp_get, out, TS_W: current time.
- o_pps, out, 1: one-cycle pulse when the integer-seconds field increments.
- o_cap_valid, out, N_CH: capture pending.
- o_cap_ts, out, N_CH*TS_W: captured times. Channel k occupies bits [k*TS_W +: TS_W].
- o_cap_ovf, out, N_CH: sticky lost-event flag.

## Operation
- Reset: divider counter, o_time_stamp_get, o_pps, o_cap_valid, o_cap_ts, o_cap_ovf and all synchroniser/edge flops are 0.
- Divider: div_cnt runs freely 0..DIV-1. A tick is the cycle in which div_cnt == DIV-1.
- Tick: o_time_stamp_get ← o_time_stamp_get + INC + sext(i_trim), computed at TS_W and wrapping modulo 2^TS_W. i_trim is registered once per tick, on the tick cycle.
- Load: when i_time_stamp_sig=1, o_time_stamp_get ← i_time_stamp_set and div_cnt ← 0. Load takes priority over a tick in the same cycle; the tick is dropped.
- PPS: o_pps=1 for one cycle after a tick whose addition changes bits [TS_W-1:FRAC_W]. A load never raises o_pps. A negative trim that causes a borrow also never raises o_pps; only an upward change counts.
- Event path per channel: the SYNC_STAGES-deep synchroniser feeds a delay flop; rise = sync & ~dly.
- Capture on rise:
  - If o_cap_valid[k]=0, or i_cap_ack[k]=1 in the same cycle: o_cap_ts[k] ← o_time_stamp_get (the registered value in that cycle) and o_cap_valid[k] ← 1.
  - If o_cap_valid[k]=1 and no ack: the capture is discarded (first wins) and o_cap_ovf[k] ← 1.
- Ack: i_cap_ack[k] with o_cap_valid[k]=1 and no rise clears o_cap_valid[k] and o_cap_ovf[k]. Ack while not valid is ignored.
- Ack plus rise in the same cycle: new capture, valid stays 1, ovf cleared.
- o_cap_ts[k] holds its last value after ack.

## Timing
- Counting from a reset release with no loads, the first increment appears after the 50th rising edge (DIV=50); increments follow every 50 cycles after that.
- A load is visible on the cycle after the strobe. The next increment comes DIV cycles after the load edge.
- o_pps is asserted on the same cycle as the incremented time value.
- Event to o_cap_valid: SYNC_STAGES+1 cycles from the first clock edge sampling i_evt high, so 3 cycles at the default.
- Events must stay high and low ≥ SYNC_STAGES+1 cycles each; shorter pulses may be missed.
- Reset mid-operation clears pending captures and ovf immediately (asynchronously). An event still high at reset release is not captured until it falls and rises again.

## Structure
- Package ts_pkg: TS_W, FRAC_W, and function calc_inc(FRAC_W, TICK_HZ), which returns INC.
- Sub-module ts_evt_capture: synchroniser, edge detect, capture register, valid/ovf/ack logic for one channel.
  - Instantiated N_CH times through a generate loop.
  - Takes the current time as an input.
- The top level holds the divider, the time accumulator and PPS detection.

## Test plan
- Reset release with defaults: o_time_stamp_get=0 through cycle 49, 4295 after edge 50, 8590 after edge 100. o_pps stays 0.
- Load 0x0000_0001_0000_0000 at cycle 23: value equals it next cycle. Next step to 0x0000_0001_0000_10C7 exactly 50 cycles after the load edge. Load coincident with a tick: the loaded value wins with no increment.
- Load 0x0000_0000_FFFF_F000, then one tick: value 0x0000_0001_0000_00C7, exactly one o_pps pulse, aligned with the value change.
- i_trim=-5: per-tick increment 4290. i_trim=+5: 4300. Trim changed mid-period takes effect at the next tick only.
- ch0 rise at time T: o_cap_valid[0]=1 three cycles later, with o_cap_ts[0] equal to o_time_stamp_get from the capture cycle. Second rise before ack: value unchanged, o_cap_ovf[0]=1. Ack: valid and ovf both clear. Ack coincident with a rise: new value, valid stays 1.
- All N_CH channels rising in the same cycle: all capture the same timestamp, independent acks. Reset asserted while valid=1: all outputs 0 at once. Event held high across reset release: no capture.
